// File: rtl/c3_issue_ctrl_pkg.sv
// Shared definitions for the C3 custom-instruction issue path.
// The RD_NONE constant is also used by the C3 unit.
package c3_issue_ctrl_pkg;

  localparam int C3_RD_W   = 5;
  localparam int C3_DATA_W = 32;

  localparam logic [C3_RD_W-1:0] C3_RD_NONE = 5'd0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WB    = 3'd4
  } c3_state_e;

endpackage

// File: rtl/c3_hazard_check.sv
// Dependency compare between the outstanding C3 destination and the
// register indices of the instruction currently in decode.
module c3_hazard_check
  import c3_issue_ctrl_pkg::*;
(
  input  logic [C3_RD_W-1:0] held_rd,
  input  logic [C3_RD_W-1:0] dec_rs1,
  input  logic [C3_RD_W-1:0] dec_rs2,
  input  logic [C3_RD_W-1:0] dec_rd,
  output logic               dep
);

  assign dep = (held_rd != C3_RD_NONE) &&
               ((held_rd == dec_rs1) || (held_rd == dec_rs2) || (held_rd == dec_rd));

endmodule

// File: rtl/c3_issue_ctrl.sv
// Core-side initiator for the C3 slot: issues one op at a time, tracks
// completion via busy/out_v, and writes results back through a valid/ready port.
module c3_issue_ctrl
  import c3_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int GUARD   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_v,
  input  logic                 dec_c3,
  input  logic [C3_RD_W-1:0]   dec_rd,
  input  logic [C3_RD_W-1:0]   dec_rs1,
  input  logic [C3_RD_W-1:0]   dec_rs2,
  input  logic [C3_DATA_W-1:0] dec_rs1_data,
  output logic                 stall,
  output logic                 cu_in_v,
  output logic [C3_RD_W-1:0]   cu_rd,
  output logic [C3_DATA_W-1:0] cu_in_data,
  input  logic                 cu_out_v,
  input  logic [C3_RD_W-1:0]   cu_out_rd,
  input  logic [C3_DATA_W-1:0] cu_out_data,
  input  logic                 cu_busy,
  output logic                 wb_v,
  output logic [C3_RD_W-1:0]   wb_rd,
  output logic [C3_DATA_W-1:0] wb_data,
  input  logic                 wb_ready,
  output logic                 err_timeout,
  input  logic                 err_clr
);

  localparam int GW = $clog2(GUARD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD);
  localparam logic [TW-1:0] TMO_LIMIT  = TW'(TIMEOUT);

  c3_state_e            state_q, state_d;
  logic [C3_RD_W-1:0]   rd_q, rd_d;
  logic [C3_DATA_W-1:0] data_q, data_d;
  logic [GW-1:0]        gcnt_q, gcnt_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic                 cap_v_q, cap_v_d;
  logic [C3_DATA_W-1:0] cap_data_q, cap_data_d;
  logic                 in_v_q, in_v_d;
  logic                 wb_v_q, wb_v_d;
  logic [C3_RD_W-1:0]   wb_rd_q, wb_rd_d;
  logic [C3_DATA_W-1:0] wb_data_q, wb_data_d;
  logic                 err_q, err_d;

  logic                 dep;
  logic                 resp_hit;
  logic                 tmo_set;
  logic [TW-1:0]        tcnt_inc;
  logic                 tmo_hit;

  c3_hazard_check u_hazard (
    .held_rd (rd_q),
    .dec_rs1 (dec_rs1),
    .dec_rs2 (dec_rs2),
    .dec_rd  (dec_rd),
    .dep     (dep)
  );

  assign stall    = (state_q != ST_IDLE) && dec_v && (dec_c3 || dep);
  assign resp_hit = cu_out_v && (cu_out_rd == rd_q) && (rd_q != C3_RD_NONE);
  assign tcnt_inc = (tcnt_q == TMO_LIMIT) ? tcnt_q : (tcnt_q + TW'(1));
  assign tmo_hit  = (tcnt_inc == TMO_LIMIT);

  // Next-state and next-output logic for the single in-flight op.
  always_comb begin
    state_d    = state_q;
    rd_d       = rd_q;
    data_d     = data_q;
    gcnt_d     = gcnt_q;
    tcnt_d     = tcnt_q;
    cap_v_d    = cap_v_q;
    cap_data_d = cap_data_q;
    in_v_d     = 1'b0;
    wb_v_d     = wb_v_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    tmo_set    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (dec_v && dec_c3 && !stall) begin
          state_d = ST_ISSUE;
          rd_d    = dec_rd;
          data_d  = dec_rs1_data;
          in_v_d  = 1'b1;
          cap_v_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_GUARD;
        gcnt_d  = GUARD_INIT;
      end
      ST_GUARD: begin
        gcnt_d = gcnt_q - GW'(1);
        // busy is not trusted yet, but an early matching result must not be lost
        if (resp_hit && !cap_v_q) begin
          cap_v_d    = 1'b1;
          cap_data_d = cu_out_data;
        end else begin
          cap_v_d    = cap_v_q;
        end
        if (gcnt_q == GW'(1)) begin
          state_d = ST_WAIT;
          tcnt_d  = {TW{1'b0}};
        end else begin
          state_d = ST_GUARD;
        end
      end
      ST_WAIT: begin
        tcnt_d = tcnt_inc;
        if (rd_q == C3_RD_NONE) begin
          if (!cu_busy) begin
            state_d = ST_IDLE;
          end else if (tmo_hit) begin
            state_d = ST_IDLE;
            tmo_set = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (cap_v_q || resp_hit || tmo_hit) begin
          state_d = ST_WB;
          wb_v_d  = 1'b1;
          wb_rd_d = rd_q;
          if (cap_v_q) begin
            wb_data_d = cap_data_q;
          end else if (resp_hit) begin
            wb_data_d = cu_out_data;
          end else begin
            // abandoned op still writes back so the dependent stall releases
            wb_data_d = {C3_DATA_W{1'b0}};
            tmo_set   = 1'b1;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_WB: begin
        if (wb_ready) begin
          state_d = ST_IDLE;
          wb_v_d  = 1'b0;
        end else begin
          state_d = ST_WB;
        end
      end
      default: begin
        state_d = ST_IDLE;
        wb_v_d  = 1'b0;
      end
    endcase

    if (tmo_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_q       <= C3_RD_NONE;
      data_q     <= {C3_DATA_W{1'b0}};
      gcnt_q     <= {GW{1'b0}};
      tcnt_q     <= {TW{1'b0}};
      cap_v_q    <= 1'b0;
      cap_data_q <= {C3_DATA_W{1'b0}};
      in_v_q     <= 1'b0;
      wb_v_q     <= 1'b0;
      wb_rd_q    <= C3_RD_NONE;
      wb_data_q  <= {C3_DATA_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      gcnt_q     <= gcnt_d;
      tcnt_q     <= tcnt_d;
      cap_v_q    <= cap_v_d;
      cap_data_q <= cap_data_d;
      in_v_q     <= in_v_d;
      wb_v_q     <= wb_v_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  assign cu_in_v     = in_v_q;
  assign cu_rd       = rd_q;
  assign cu_in_data  = data_q;
  assign wb_v        = wb_v_q;
  assign wb_rd       = wb_rd_q;
  assign wb_data     = wb_data_q;
  assign err_timeout = err_q;

endmodule
